// File: rtl/io_keysw_dev.sv
// Memory-mapped pushbutton/switch input peripheral: synchronizes and debounces
// KEY and SW, latches per-device ready/overrun flags, and raises an interrupt.

module io_keysw_deb #(
  parameter int W               = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] d_o,
  output logic         chg_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]  ff1_q, ff2_q, d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The count only advances while the synchronized value is steady and
  // differs from the accepted value; any disturbance restarts it.
  always_comb begin
    cnt_d = cnt_q;
    d_d   = d_q;
    chg_o = 1'b0;
    if ((ff1_q != ff2_q) || (ff2_q == d_q)) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      d_d   = ff2_q;
      cnt_d = '0;
      chg_o = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ff1_q <= '0;
      ff2_q <= '0;
      d_q   <= '0;
      cnt_q <= '0;
    end else begin
      ff1_q <= raw_i;
      ff2_q <= ff1_q;
      d_q   <= d_d;
      cnt_q <= cnt_d;
    end
  end

  assign d_o = d_q;
endmodule

module io_keysw_dev #(
  parameter int                DBITS           = 32,
  parameter int                DEBOUNCE_CYCLES = 500000,
  parameter logic [DBITS-1:0]  ADDRKEY         = 32'hF0000010,
  parameter logic [DBITS-1:0]  ADDRSW          = 32'hF0000014,
  parameter logic [DBITS-1:0]  ADDRKCTRL       = 32'hF0000110,
  parameter logic [DBITS-1:0]  ADDRSCTRL       = 32'hF0000114
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  input  logic [DBITS-1:0] addr,
  input  logic             wr_en,
  input  logic [DBITS-1:0] wdata,
  input  logic             rd_commit,
  output logic             sel,
  output logic [DBITS-1:0] rdata,
  output logic             irq
);
  logic [3:0] kd;
  logic [9:0] sd;
  logic       kchg, schg;

  // Pushbuttons are active-low on the pins; present them as pressed=1.
  io_keysw_deb #(.W(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_kdeb (
    .clk     (clk),
    .reset_n (reset_n),
    .raw_i   (~KEY),
    .d_o     (kd),
    .chg_o   (kchg)
  );

  io_keysw_deb #(.W(10), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sdeb (
    .clk     (clk),
    .reset_n (reset_n),
    .raw_i   (SW),
    .d_o     (sd),
    .chg_o   (schg)
  );

  logic hit_kdata, hit_sdata, hit_kctrl, hit_sctrl;
  logic rd_kdata, rd_sdata, wr_kctrl, wr_sctrl;

  assign hit_kdata = (addr == ADDRKEY);
  assign hit_sdata = (addr == ADDRSW);
  assign hit_kctrl = (addr == ADDRKCTRL);
  assign hit_sctrl = (addr == ADDRSCTRL);
  assign sel       = hit_kdata | hit_sdata | hit_kctrl | hit_sctrl;
  assign rd_kdata  = rd_commit & hit_kdata;
  assign rd_sdata  = rd_commit & hit_sdata;
  assign wr_kctrl  = wr_en & hit_kctrl;
  assign wr_sctrl  = wr_en & hit_sctrl;

  logic kready_q, kready_d, kovr_q, kovr_d, kie_q, kie_d;
  logic sready_q, sready_d, sovr_q, sovr_d, sie_q, sie_d;
  logic irq_q, irq_d;

  // A change event outranks both a same-cycle data read (ready stays set,
  // no overrun) and a same-cycle control write (overrun stays set).
  always_comb begin
    kready_d = kready_q;
    kovr_d   = kovr_q;
    kie_d    = kie_q;
    if (wr_kctrl) begin
      kie_d = wdata[8];
      if (!wdata[2]) kovr_d = 1'b0;
    end
    if (rd_kdata) kready_d = 1'b0;
    if (kchg) begin
      kready_d = 1'b1;
      if (kready_q && !rd_kdata) kovr_d = 1'b1;
    end
  end

  always_comb begin
    sready_d = sready_q;
    sovr_d   = sovr_q;
    sie_d    = sie_q;
    if (wr_sctrl) begin
      sie_d = wdata[8];
      if (!wdata[2]) sovr_d = 1'b0;
    end
    if (rd_sdata) sready_d = 1'b0;
    if (schg) begin
      sready_d = 1'b1;
      if (sready_q && !rd_sdata) sovr_d = 1'b1;
    end
  end

  assign irq_d = (kready_q & kie_q) | (sready_q & sie_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kready_q <= 1'b0;
      kovr_q   <= 1'b0;
      kie_q    <= 1'b0;
      sready_q <= 1'b0;
      sovr_q   <= 1'b0;
      sie_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      kready_q <= kready_d;
      kovr_q   <= kovr_d;
      kie_q    <= kie_d;
      sready_q <= sready_d;
      sovr_q   <= sovr_d;
      sie_q    <= sie_d;
      irq_q    <= irq_d;
    end
  end

  assign irq = irq_q;

  logic [8:0] kctrl_word, sctrl_word;
  assign kctrl_word = {kie_q, 5'b0, kovr_q, 1'b0, kready_q};
  assign sctrl_word = {sie_q, 5'b0, sovr_q, 1'b0, sready_q};

  always_comb begin
    rdata = '0;
    if (hit_kdata)      rdata = DBITS'(kd);
    else if (hit_sdata) rdata = DBITS'(sd);
    else if (hit_kctrl) rdata = DBITS'(kctrl_word);
    else if (hit_sctrl) rdata = DBITS'(sctrl_word);
  end

  // Only wdata bits 8 and 2 carry meaning in this block.
  logic unused_wdata;
  assign unused_wdata = ^{wdata[DBITS-1:9], wdata[7:3], wdata[1:0]};
endmodule
